// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Instruction memory that is filled from a byte stream and then serves
// combinational instruction fetches to a CPU. Bytes are packed little-endian
// into 32-bit words. A word can be fetched only after it has been written
// during the current load.
//
// While loading, the CPU is held in reset. When the stream ends (load_last),
// or when the memory fills up, the block switches to RUN and releases the CPU.
//
// Parameters
//   DEPTH  instruction memory size in 32-bit words (power of two, >= 4)
//   BASE   byte address of word 0 (CPU text segment)
//   FILL   word returned for any invalid fetch (default is a nop)
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous active-high reset, overrides every other input
//   load_valid   a loader byte is offered this cycle
//   load_data    program byte
//   load_last    offered byte is the final byte of the program
//   load_ready   block accepts a byte this cycle (high only while loading)
//   reload       single-cycle request to restart loading (effective in RUN)
//   PC           CPU fetch address
//   Instr        fetched instruction, combinational from PC
//   cpu_rst      registered reset to the CPU, high for every LOAD cycle
//   fault        sticky flag, set by any invalid fetch while running
//   load_full    sticky flag, memory filled without seeing load_last
//   words_loaded number of words written in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned DEPTH = 256,
    parameter logic [31:0] BASE  = 32'h00400000,
    parameter logic [31:0] FILL  = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic [7:0]               load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    input  logic                     reload,
    input  logic [31:0]              PC,
    output logic [31:0]              Instr,
    output logic                     cpu_rst,
    output logic                     fault,
    output logic                     load_full,
    output logic [$clog2(DEPTH):0]   words_loaded
);

    localparam int AW = $clog2(DEPTH);
    localparam int WL = AW + 1;
    localparam logic [31:0]   SPAN    = 32'(4 * DEPTH);
    localparam logic [AW-1:0] LAST_IX = AW'(DEPTH - 1);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [31:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [23:0]     r_asm;
    logic [1:0]      r_byteCnt;
    logic [WL-1:0]   r_wordsLoaded;
    logic            r_fault;
    logic            r_loadFull;
    logic            r_cpuRst;

    logic            w_accept;
    logic            w_wordDone;
    logic            w_fillUp;
    logic [AW-1:0]   w_wrIdx;
    logic [31:0]     w_word;
    logic [31:0]     w_offset;
    logic [AW-1:0]   w_rdIdx;
    logic            w_inRange;
    logic            w_fetchOk;

    // Write side. words_loaded never reaches DEPTH while loading, because the
    // write into the last slot always ends the load, so its low bits index
    // the next free word directly.
    assign w_accept   = (r_state == LOAD) && load_valid;
    assign w_wordDone = w_accept && ((r_byteCnt == 2'd3) || load_last);
    assign w_wrIdx    = r_wordsLoaded[AW-1:0];
    assign w_fillUp   = w_wordDone && (w_wrIdx == LAST_IX) && !load_last;

    // Build the word being written from the lanes collected so far plus the
    // current byte. Lanes not yet received in this word read as zero, which
    // gives the zero-padded partial word when the stream ends early.
    always_comb begin
        w_word = 32'h0;
        case (r_byteCnt)
            2'd0: w_word = {24'h0, load_data};
            2'd1: w_word = {16'h0, load_data, r_asm[7:0]};
            2'd2: w_word = {8'h0, load_data, r_asm[15:0]};
            2'd3: w_word = {load_data, r_asm};
            default: w_word = 32'h0;
        endcase
    end

    // Fetch side. The range test uses the wrapped offset from BASE, so it
    // never has to form BASE+4*DEPTH, which could overflow 32 bits.
    assign w_offset  = PC - BASE;
    assign w_rdIdx   = w_offset[AW+1:2];
    assign w_inRange = (PC >= BASE) && (w_offset < SPAN);
    assign w_fetchOk = (r_state == RUN) && (PC[1:0] == 2'b00) && w_inRange
                       && r_valid[w_rdIdx];

    assign Instr        = w_fetchOk ? r_mem[w_rdIdx] : FILL;
    assign load_ready   = (r_state == LOAD);
    assign cpu_rst      = r_cpuRst;
    assign fault        = r_fault;
    assign load_full    = r_loadFull;
    assign words_loaded = r_wordsLoaded;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state. A load ends on its last byte or when the final slot fills.
    // reload only has an effect while running.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            LOAD: begin
                if (w_accept && (load_last || w_fillUp)) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    w_nextState = LOAD;
                end
            end
            default: w_nextState = LOAD;
        endcase
    end

    // Control and status registers. cpu_rst follows the next state so that it
    // is high for exactly the LOAD cycles. A reload in RUN discards the whole
    // program by clearing the valid bits. The stored words themselves are
    // left in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm         <= 24'h0;
            r_byteCnt     <= 2'd0;
            r_wordsLoaded <= '0;
            r_valid       <= '0;
            r_fault       <= 1'b0;
            r_loadFull    <= 1'b0;
            r_cpuRst      <= 1'b1;
        end else begin
            r_cpuRst <= (w_nextState == LOAD);
            if ((r_state == RUN) && reload) begin
                r_byteCnt     <= 2'd0;
                r_wordsLoaded <= '0;
                r_valid       <= '0;
                r_fault       <= 1'b0;
                r_loadFull    <= 1'b0;
            end else begin
                if (w_accept) begin
                    case (r_byteCnt)
                        2'd0: r_asm[7:0]   <= load_data;
                        2'd1: r_asm[15:8]  <= load_data;
                        2'd2: r_asm[23:16] <= load_data;
                        default: ;
                    endcase
                    r_byteCnt <= load_last ? 2'd0 : r_byteCnt + 2'd1;
                end
                if (w_wordDone) begin
                    r_valid[w_wrIdx] <= 1'b1;
                    r_wordsLoaded    <= r_wordsLoaded + WL'(1);
                end
                if (w_fillUp) begin
                    r_loadFull <= 1'b1;
                end
                if ((r_state == RUN) && !w_fetchOk) begin
                    r_fault <= 1'b1;
                end
            end
        end
    end

    // Program storage. The array has no reset. Validity is tracked separately.
    always_ff @(posedge clk) begin
        if (!rst && w_wordDone) begin
            r_mem[w_wrIdx] <= w_word;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed testbench for imem_loader. It runs a default instance (DEPTH=256)
// and a small instance (DEPTH=4). Both instances share the same input stimulus.
// Each check is tied to the instance it targets. All expected values are
// written here by hand.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h00400000;
    localparam logic [31:0] FILL = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        reload;
    logic [31:0] PC;

    logic        ready0, cpuRst0, fault0, full0;
    logic [31:0] instr0;
    logic [8:0]  wl0;

    logic        ready1, cpuRst1, fault1, full1;
    logic [31:0] instr1;
    logic [2:0]  wl1;

    int nCompared = 0;
    int nFail     = 0;

    imem_loader u0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(ready0), .reload(reload), .PC(PC),
        .Instr(instr0), .cpu_rst(cpuRst0), .fault(fault0), .load_full(full0),
        .words_loaded(wl0)
    );

    imem_loader #(.DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(ready1), .reload(reload), .PC(PC),
        .Instr(instr1), .cpu_rst(cpuRst1), .fault(fault1), .load_full(full1),
        .words_loaded(wl1)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
        reload = 1'b0; PC = BASE;
        tick();

        // Reset state of both instances
        checkOutput("rst cpu_rst",    32'(cpuRst0), 32'd1);
        checkOutput("rst ready",      32'(ready0),  32'd1);
        checkOutput("rst fault",      32'(fault0),  32'd0);
        checkOutput("rst load_full",  32'(full0),   32'd0);
        checkOutput("rst words",      32'(wl0),     32'd0);
        checkOutput("rst Instr",      instr0,       FILL);
        checkOutput("rst words d4",   32'(wl1),     32'd0);
        rst = 1'b0;

        // Fill the DEPTH=4 instance with 16 bytes and no last marker
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(8'(i), 1'b0);
            if (i == 12) begin
                checkOutput("d4 words@12", 32'(wl1),    32'd3);
                checkOutput("d4 ready@12", 32'(ready1), 32'd1);
                checkOutput("d4 full@12",  32'(full1),  32'd0);
            end
        end
        checkOutput("d4 load_full",  32'(full1),   32'd1);
        checkOutput("d4 words",      32'(wl1),     32'd4);
        checkOutput("d4 ready",      32'(ready1),  32'd0);
        checkOutput("d4 cpu_rst",    32'(cpuRst1), 32'd0);
        checkOutput("d256 words@16", 32'(wl0),     32'd4);
        checkOutput("d256 ready@16", 32'(ready0),  32'd1);
        checkOutput("d256 full@16",  32'(full0),   32'd0);
        PC = 32'h0040000C; #1;
        checkOutput("d4 word3",      instr1,       32'h100F0E0D);
        PC = 32'h00400010; #1;
        checkOutput("d4 past end",   instr1,       FILL);

        rst = 1'b1; tick(); rst = 1'b0;

        // Two-word program, then a fetch beyond the program
        PC = 32'h00400004;
        applyStimulus(8'h13, 1'b0); applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0); applyStimulus(8'h00, 1'b0);
        checkOutput("p1 words@4",    32'(wl0),     32'd1);
        applyStimulus(8'h93, 1'b0); applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h10, 1'b0);
        checkOutput("p1 cpu_rst@7",  32'(cpuRst0), 32'd1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("p1 words",      32'(wl0),     32'd2);
        checkOutput("p1 cpu_rst",    32'(cpuRst0), 32'd0);
        checkOutput("p1 ready",      32'(ready0),  32'd0);
        checkOutput("p1 word1",      instr0,       32'h00100093);
        PC = 32'h00400008; #1;
        checkOutput("p1 word2 fill", instr0,       FILL);
        checkOutput("p1 fault pre",  32'(fault0),  32'd0);
        tick();
        checkOutput("p1 fault",      32'(fault0),  32'd1);

        // Reload, then a partial one-word program
        reload = 1'b1; PC = BASE; tick(); reload = 1'b0;
        checkOutput("rl fault clr",  32'(fault0),  32'd0);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b1);
        checkOutput("p2 words",      32'(wl0),     32'd1);
        checkOutput("p2 word0",      instr0,       32'h0000BBAA);
        tick();
        checkOutput("p2 fault",      32'(fault0),  32'd0);

        // Misaligned fetch, then the fault flag stays set
        PC = 32'h00400002; #1;
        checkOutput("mis Instr",     instr0,       FILL);
        tick();
        checkOutput("mis fault",     32'(fault0),  32'd1);
        PC = BASE; tick();
        checkOutput("mis sticky",    32'(fault0),  32'd1);
        checkOutput("mis word0",     instr0,       32'h0000BBAA);

        // Reload together with a byte in RUN. The byte must be dropped.
        reload = 1'b1; load_valid = 1'b1; load_data = 8'h55;
        tick();
        reload = 1'b0; load_valid = 1'b0;
        checkOutput("rlv cpu_rst",   32'(cpuRst0), 32'd1);
        checkOutput("rlv words",     32'(wl0),     32'd0);
        checkOutput("rlv fault",     32'(fault0),  32'd0);
        checkOutput("rlv ready",     32'(ready0),  32'd1);
        checkOutput("rlv Instr",     instr0,       FILL);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b1);
        checkOutput("rlv word0",     instr0,       32'h00002211);
        checkOutput("rlv words2",    32'(wl0),     32'd1);

        // Reset in the middle of a load. A byte offered with rst is ignored.
        reload = 1'b1; tick(); reload = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'hA1 + 8'(i), 1'b0);
        end
        checkOutput("mid words@6",   32'(wl0),     32'd1);
        rst = 1'b1; load_valid = 1'b1; load_data = 8'hEE; load_last = 1'b1;
        tick();
        rst = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        checkOutput("mid rst words", 32'(wl0),     32'd0);
        checkOutput("mid rst cpu",   32'(cpuRst0), 32'd1);
        checkOutput("mid rst ready", 32'(ready0),  32'd1);
        applyStimulus(8'h01, 1'b0); applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h03, 1'b0); applyStimulus(8'h04, 1'b1);
        checkOutput("mid words",     32'(wl0),     32'd1);
        checkOutput("mid word0",     instr0,       32'h04030201);
        PC = 32'h00400004; #1;
        checkOutput("mid word1 inv", instr0,       FILL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 256, meaning the instruction memory size in 32-bit words; DEPTH is a power of two and at least 4.
REQ-002 The block SHALL expose parameter BASE, default 32'h00400000, meaning the byte address of word 0, which is the CPU text segment.
REQ-003 The block SHALL expose parameter FILL, default 32'h00000013 (nop), meaning the word returned for any invalid fetch.
REQ-004 clk  in  1  single clock; all state updates on the posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 load_valid  in  1  loader byte offered.
REQ-007 load_data  in  8  program byte; little-endian within each word.
REQ-008 load_last  in  1  marks the final byte of the program; qualified by load_valid.
REQ-009 load_ready  out  1  block accepts a byte this cycle.
REQ-010 reload  in  1  single-cycle request to restart loading.
REQ-011 PC  in  32  CPU fetch address.
REQ-012 Instr  out  32  fetched instruction; combinational from PC.
REQ-013 cpu_rst  out  1  registered reset to the CPU, active high.
REQ-014 fault  out  1  sticky flag for a bad fetch.
REQ-015 load_full  out  1  sticky flag set when memory filled without load_last.
REQ-016 words_loaded  out  $clog2(DEPTH)+1  count of words written in the current load.

Function
REQ-017 The FSM SHALL have exactly two states, LOAD and RUN; rst forces LOAD.
REQ-018 A byte SHALL be accepted only on a cycle with load_valid=1 and load_ready=1; load_ready SHALL equal (state==LOAD).
REQ-019 An accepted byte SHALL be placed in lane byte_cnt of the assembly register (lane 0 = bits 7:0), and byte_cnt SHALL then increment modulo 4.
REQ-020 On the 4th accepted byte, the full word SHALL be written at index words_loaded, that word's valid bit SHALL be set, and words_loaded SHALL increment at the same edge.
REQ-021 An accepted byte with load_last=1 and byte_cnt<3 SHALL write the partial word with unreceived upper lanes zero, set its valid bit, and increment words_loaded.
REQ-022 An accepted byte with load_last=1 SHALL move the FSM to RUN at that edge; byte_cnt SHALL clear.
REQ-023 A word write at index DEPTH-1 without load_last SHALL move the FSM to RUN at that edge and set load_full.
REQ-024 cpu_rst SHALL be 1 in every cycle in which state==LOAD and 0 in RUN, so the CPU samples reset high at the transition edge and fetches BASE in the first RUN cycle.
REQ-025 A fetch SHALL be valid when all of the following hold: state==RUN; PC[1:0]==0; BASE <= PC < BASE+4*DEPTH; and the valid bit of word (PC-BASE)>>2 is set.
REQ-026 For a valid fetch, Instr SHALL equal the stored word; for any other fetch, Instr SHALL equal FILL.
REQ-027 fault SHALL set at the posedge of any RUN cycle with an invalid fetch and SHALL hold until rst or reload.
REQ-028 reload=1 in RUN SHALL move the FSM to LOAD and clear words_loaded, byte_cnt, all valid bits, fault and load_full at that edge; stored data need not be cleared.
REQ-029 reload in LOAD SHALL be ignored, and the byte offered that cycle SHALL be accepted normally.
REQ-030 When reload and load_valid are both high in RUN, reload SHALL win, and no byte is accepted because load_ready=0.
REQ-031 The block SHALL not inspect instruction contents.

Reset
REQ-032 On rst, the block SHALL enter LOAD with cpu_rst=1, load_ready=1, fault=0, load_full=0, words_loaded=0, byte_cnt=0, all valid bits clear and Instr=FILL.
REQ-033 rst mid-load SHALL discard any partial word and all previously written words, leaving them invalid.
REQ-034 rst SHALL take priority over reload, load_valid and load_last.

Verification
REQ-035 Load bytes 13 00 00 00 93 00 10 00 with load_last on byte 8 -> words_loaded=2, cpu_rst falls at that edge; PC=0x00400004 -> Instr=0x00100093; PC=0x00400008 -> Instr=0x00000013 and fault=1 next cycle.
REQ-036 Load bytes AA BB with load_last on BB -> words_loaded=1; PC=0x00400000 -> Instr=0x0000BBAA; fault stays 0.
REQ-037 After a valid load, PC=0x00400002 -> Instr=FILL and fault=1 at the next edge; then PC=0x00400000 -> fault remains 1.
REQ-038 With DEPTH=4, stream 16 bytes and no load_last -> the FSM enters RUN after byte 16, load_full=1, words_loaded=4, load_ready=0; PC=0x00400010 -> Instr=FILL.
REQ-039 In RUN, assert reload together with load_valid -> the next cycle has cpu_rst=1, words_loaded=0, fault=0, and PC=0x00400000 -> Instr=FILL; the concurrent byte is not stored.
REQ-040 Assert rst after 6 accepted bytes, then load 4 bytes 01 02 03 04 with last -> word 0 = 0x04030201 and word 1 is invalid.
